// File: rtl/fifo_frame_ctrl_pkg.sv
// Shared constants and state encoding for the FIFO frame controller.
package fifo_frame_ctrl_pkg;

  localparam int unsigned FIFO_DEPTH        = 32;
  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StSync = 3'd1,
    StLen  = 3'd2,
    StData = 3'd3,
    StChk  = 3'd4
  } state_t;

endpackage

// File: rtl/fifo_frame_ctrl_idle_timer.sv
// Idle timer: counts enabled cycles, saturates at TIMEOUT-1 and flags expiry.
module frame_idle_timer #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expire
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_count && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expire = (r_cnt == LAST);

endmodule

// File: rtl/fifo_frame_ctrl.sv
// Drains an external byte FIFO into SYNC/LEN/payload/CHK frames toward a ready/valid sink.
module fifo_frame_ctrl
  import fifo_frame_ctrl_pkg::*;
#(
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned TIMEOUT   = 1000,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fifo_write,
  input  logic       fifo_full,
  input  logic       fifo_data_present,
  input  logic [7:0] fifo_data_out,
  output logic       fifo_read,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       overflow
);

  localparam logic [5:0] W_BURST = 6'(BURST_LEN);
  localparam logic [5:0] W_DEPTH = 6'(FIFO_DEPTH);

  state_t     r_state;
  state_t     w_state_next;
  logic [5:0] r_occ;
  logic [5:0] r_len;
  logic [5:0] r_rem;
  logic [7:0] r_chk;
  logic       r_overflow;

  logic       w_wr;
  logic       w_start;
  logic       w_expire;
  logic       w_tmr_clear;
  logic       w_tmr_count;

  assign w_wr    = fifo_write && !fifo_full && (r_occ != W_DEPTH);
  assign w_start = (r_state == StIdle) &&
                   ((r_occ >= W_BURST) || (w_expire && (r_occ != 6'd0)));

  assign w_tmr_clear = fifo_write || (r_state != StIdle) || (r_occ == 6'd0) || w_start;
  assign w_tmr_count = (r_state == StIdle) && (r_occ != 6'd0) && (r_occ < W_BURST);

  frame_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_tmr_clear),
    .i_count  (w_tmr_count),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_next = r_state;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    unique case (r_state)
      StIdle: begin
        if (w_start) w_state_next = StSync;
      end
      StSync: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_BYTE;
        if (tx_ready) w_state_next = StLen;
      end
      StLen: begin
        tx_valid = 1'b1;
        tx_data  = {2'b00, r_len};
        if (tx_ready) w_state_next = StData;
      end
      StData: begin
        tx_valid = 1'b1;
        tx_data  = fifo_data_out;
        if (tx_ready && (r_rem == 6'd1)) w_state_next = StChk;
      end
      StChk: begin
        tx_valid = 1'b1;
        tx_data  = r_chk;
        if (tx_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign fifo_read = (r_state == StData) && tx_valid && tx_ready;
  assign busy      = (r_state != StIdle);
  assign overflow  = r_overflow;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_occ      <= 6'd0;
      r_len      <= 6'd0;
      r_rem      <= 6'd0;
      r_chk      <= 8'h00;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // Simultaneous push and pop leave occupancy unchanged.
      if (w_wr && !fifo_read) begin
        r_occ <= r_occ + 6'd1;
      end else if (!w_wr && fifo_read) begin
        r_occ <= r_occ - 6'd1;
      end
      if (w_start) begin
        r_len <= (r_occ >= W_BURST) ? W_BURST : r_occ;
      end
      if ((r_state == StLen) && tx_ready) begin
        r_rem <= r_len;
      end else if (fifo_read) begin
        r_rem <= r_rem - 6'd1;
      end
      if ((r_state == StSync) && tx_ready) begin
        r_chk <= {2'b00, r_len};
      end else if (fifo_read) begin
        r_chk <= r_chk + fifo_data_out;
      end
      if (fifo_write && fifo_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // LEN never exceeds occupancy, so a pop always finds data.
  a_no_empty_pop: assert property (@(posedge clk) disable iff (reset)
    fifo_read |-> fifo_data_present);

endmodule

// File: tb/tb_fifo_frame_ctrl.sv
// Directed bench for fifo_frame_ctrl with a behavioural 32x8 FIFO and a tx byte monitor.
module tb_fifo_frame_ctrl;

  localparam int unsigned BURST = 16;
  localparam int unsigned TMO   = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       fifo_write;
  logic       fifo_full;
  logic       fifo_data_present;
  logic [7:0] fifo_data_out;
  logic [7:0] fifo_din;
  logic       fifo_read;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       overflow;

  always #5 clk = ~clk;

  fifo_frame_ctrl #(
    .BURST_LEN (BURST),
    .TIMEOUT   (TMO),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .fifo_write        (fifo_write),
    .fifo_full         (fifo_full),
    .fifo_data_present (fifo_data_present),
    .fifo_data_out     (fifo_data_out),
    .fifo_read         (fifo_read),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .busy              (busy),
    .overflow          (overflow)
  );

  // Behavioural FIFO standing in for the external bbfifo_32x8.
  logic [7:0] m_mem [32];
  logic [4:0] m_rd;
  logic [4:0] m_wr;
  logic [5:0] m_cnt;

  assign fifo_full         = (m_cnt == 6'd32);
  assign fifo_data_present = (m_cnt != 6'd0);
  assign fifo_data_out     = m_mem[m_rd];

  always @(posedge clk) begin
    if (reset) begin
      m_rd  <= 5'd0;
      m_wr  <= 5'd0;
      m_cnt <= 6'd0;
    end else begin
      if (fifo_write && !fifo_full) begin
        m_mem[m_wr] <= fifo_din;
        m_wr        <= m_wr + 5'd1;
      end
      if (fifo_read) m_rd <= m_rd + 5'd1;
      m_cnt <= m_cnt + 6'(fifo_write && !fifo_full) - 6'(fifo_read);
    end
  end

  logic [7:0] cap [$];
  int         pops = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (tx_valid && tx_ready) cap.push_back(tx_data);
      if (fifo_read) pops++;
    end
  end

  int n_err = 0;
  int n_chk = 0;
  int rdp   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] b);
    check(tag, (rdp < cap.size()) ? int'(cap[rdp]) : -1, int'(b));
    rdp++;
  endtask

  task automatic expect_frame(input string tag, input int len, input logic [7:0] first,
                              input logic [7:0] chk);
    expect_byte({tag, "_sync"}, 8'hA5);
    expect_byte({tag, "_len"}, 8'(len));
    for (int i = 0; i < len; i++) begin
      expect_byte($sformatf("%s_d%0d", tag, i), first + 8'(i));
    end
    expect_byte({tag, "_chk"}, chk);
  endtask

  task automatic write_bytes(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_write = 1'b1;
      fifo_din   = first + 8'(i);
      @(posedge clk); #1;
    end
    fifo_write = 1'b0;
  endtask

  task automatic wait_busy(input string tag, input logic lvl, output int n);
    n = 0;
    while ((busy !== lvl) && (n < 300)) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_reach"}, int'(busy), int'(lvl));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int p0;
    int r0;
    int st_reads;
    int st_changes;
    logic [7:0] held;

    reset      = 1'b1;
    fifo_write = 1'b0;
    fifo_din   = 8'h00;
    tx_ready   = 1'b1;
    idle(3);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_fifo_read", fifo_read, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_occ", dut.r_occ, 0);
    reset = 1'b0;
    idle(2);

    // Full burst: starts the cycle after occupancy reaches BURST_LEN.
    p0 = pops;
    write_bytes(8'h01, 16);
    wait_busy("t1_start", 1'b1, n);
    check("t1_latency", n, 1);
    wait_busy("t1_end", 1'b0, n);
    expect_frame("t1", 16, 8'h01, 8'h98);
    check("t1_pops", pops - p0, 16);
    check("t1_occ", dut.r_occ, 0);
    check("t1_overflow", overflow, 0);

    // Partial frame flushed after exactly TIMEOUT idle cycles.
    write_bytes(8'h01, 3);
    wait_busy("t2_start", 1'b1, n);
    check("t2_latency", n, TMO);
    wait_busy("t2_end", 1'b0, n);
    expect_frame("t2", 3, 8'h01, 8'h09);

    // Back-pressure for 5 cycles mid-payload.
    p0 = pops;
    write_bytes(8'h41, 8);
    wait_busy("t3_start", 1'b1, n);
    n = 0;
    while ((pops - p0 < 3) && (n < 100)) begin
      @(posedge clk); #1;
      n++;
    end
    check("t3_pops_before_stall", pops - p0, 3);
    tx_ready   = 1'b0;
    held       = tx_data;
    st_reads   = 0;
    st_changes = 0;
    check("t3_held_byte", held, 8'h44);
    repeat (5) begin
      @(posedge clk); #1;
      if (fifo_read) st_reads++;
      if (tx_data !== held) st_changes++;
    end
    check("t3_stall_reads", st_reads, 0);
    check("t3_stall_changes", st_changes, 0);
    check("t3_stall_valid", tx_valid, 1);
    tx_ready = 1'b1;
    wait_busy("t3_end", 1'b0, n);
    expect_frame("t3", 8, 8'h41, 8'h2C);
    check("t3_pops", pops - p0, 8);

    // 20 bytes: LEN=16 frame, then a LEN=4 frame after timeout.
    write_bytes(8'h21, 20);
    wait_busy("t4a_start", 1'b1, n);
    wait_busy("t4a_end", 1'b0, n);
    expect_frame("t4a", 16, 8'h21, 8'h98);
    check("t4_occ_between", dut.r_occ, 4);
    wait_busy("t4b_start", 1'b1, n);
    wait_busy("t4b_end", 1'b0, n);
    expect_frame("t4b", 4, 8'h31, 8'hCE);
    check("t4_occ", dut.r_occ, 0);

    // Reset during DATA abandons the frame.
    p0 = pops;
    r0 = cap.size();
    write_bytes(8'h51, 5);
    wait_busy("t5_start", 1'b1, n);
    n = 0;
    while ((pops - p0 < 2) && (n < 100)) begin
      @(posedge clk); #1;
      n++;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t5_tx_valid", tx_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_occ", dut.r_occ, 0);
    check("t5_fifo_read", fifo_read, 0);
    idle(40);
    check("t5_bytes", cap.size() - r0, 4);
    expect_byte("t5_sync", 8'hA5);
    expect_byte("t5_len", 8'h05);
    expect_byte("t5_d0", 8'h51);
    expect_byte("t5_d1", 8'h52);
    rdp = cap.size();
    write_bytes(8'h61, 2);
    wait_busy("t5b_start", 1'b1, n);
    wait_busy("t5b_end", 1'b0, n);
    expect_frame("t5b", 2, 8'h61, 8'hC5);

    // Fill to full with the sink stalled, then write once more.
    p0 = pops;
    tx_ready = 1'b0;
    write_bytes(8'h70, 32);
    check("t6_occ_full", dut.r_occ, 32);
    check("t6_no_overflow", overflow, 0);
    write_bytes(8'h90, 1);
    check("t6_overflow", overflow, 1);
    check("t6_occ_cap", dut.r_occ, 32);
    check("t6_sync_held", tx_data, 8'hA5);
    idle(5);
    check("t6_overflow_sticky", overflow, 1);
    check("t6_pops", pops - p0, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t6_overflow_clr", overflow, 0);
    check("t6_busy_clr", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_frame_ctrl.md
FIFO_FRAME_CTRL -- requirements
Module: fifo_frame_ctrl

Interface
REQ-001 Parameter BURST_LEN, default 16, maximum payload bytes per frame, range 1..32.
REQ-002 Parameter TIMEOUT, default 1000, idle cycles before a partial frame is flushed, minimum 2.
REQ-003 Parameter SYNC_BYTE, default 8'hA5, first byte of every frame.
REQ-004 Port clk, input, 1, the single clock; all logic on the rising edge.
REQ-005 Port reset, input, 1, synchronous active-high reset, also wired to the bbfifo_32x8 reset.
REQ-006 Port fifo_write, input, 1, copy of the FIFO write strobe, monitored only.
REQ-007 Port fifo_full, input, 1, FIFO full flag.
REQ-008 Port fifo_data_present, input, 1, FIFO non-empty flag.
REQ-009 Port fifo_data_out, input, 8, oldest FIFO byte, valid while fifo_data_present=1.
REQ-010 Port fifo_read, output, 1, one-cycle pop strobe to the FIFO.
REQ-011 Port tx_data, output, 8, frame byte to the downstream transmitter.
REQ-012 Port tx_valid, output, 1, tx_data valid.
REQ-013 Port tx_ready, input, 1, downstream accepts tx_data when tx_valid=1 and tx_ready=1.
REQ-014 Port busy, output, 1, high in any state other than IDLE.
REQ-015 Port overflow, output, 1, sticky: set when fifo_write=1 and fifo_full=1.

Function
REQ-016 Frame format SHALL be SYNC_BYTE, LEN, LEN payload bytes, CHK; CHK is the modulo-256 sum of LEN and all payload bytes.
REQ-017 Occupancy counter occ (6 bits, 0..32) SHALL add 1 on fifo_write and not fifo_full, subtract 1 on fifo_read, and stay unchanged when both occur.
REQ-018 States SHALL be IDLE, SYNC, LEN, DATA, CHK.
REQ-019 IDLE to SYNC SHALL happen when occ >= BURST_LEN, or when the idle timer reaches TIMEOUT-1 with occ > 0.
REQ-020 LEN SHALL be latched on the IDLE-to-SYNC transition as min(occ, BURST_LEN).
REQ-021 The idle timer SHALL count only in IDLE with 0 < occ < BURST_LEN, and SHALL clear on any fifo_write, on leaving IDLE, and when occ = 0.
REQ-022 tx_valid SHALL be 1 in SYNC, LEN, DATA and CHK, and 0 in IDLE.
REQ-023 tx_data SHALL be SYNC_BYTE in SYNC, the latched LEN in LEN, fifo_data_out in DATA, and the checksum in CHK.
REQ-024 Each state SHALL advance only on a cycle with tx_valid and tx_ready both high: SYNC to LEN, LEN to DATA, DATA to CHK after the LEN-th payload byte, CHK to IDLE.
REQ-025 While tx_ready=0, tx_data SHALL hold stable and no state change or FIFO pop SHALL occur.
REQ-026 fifo_read SHALL be combinational and equal (state==DATA) AND tx_valid AND tx_ready, so exactly one pop occurs per accepted payload byte.
REQ-027 The remaining-byte counter SHALL load LEN in LEN state and decrement on each pop; DATA exits when it reaches 1 and is accepted.
REQ-028 The checksum accumulator SHALL load LEN on the SYNC-to-LEN acceptance and add each popped byte.
REQ-029 FIFO writes during a frame SHALL only raise occ; LEN is never modified after it is latched.
REQ-030 A back-to-back frame SHALL be permitted: IDLE re-evaluates REQ-019 on the cycle after CHK is accepted.
REQ-031 fifo_read SHALL never assert when fifo_data_present=0; this is guaranteed by LEN <= occ.

Reset
REQ-032 While reset=1 at a clock edge: state=IDLE, occ=0, timer=0, checksum=0, overflow=0.
REQ-033 Reset outputs SHALL be tx_valid=0, tx_data=8'h00, fifo_read=0, busy=0, overflow=0.
REQ-034 Reset mid-frame SHALL abandon the frame without emitting CHK; the next frame starts with SYNC.

Structure
REQ-035 A shared package SHALL hold the state encoding, the SYNC_BYTE default and the FIFO depth constant 32.
REQ-036 The FIFO SHALL remain external to this block.
REQ-037 One sub-module, frame_idle_timer (the TIMEOUT counter with clear and expire), is natural; everything else is flat.

Verification
REQ-038 Write 16 bytes 01..10 with tx_ready=1 -> tx stream A5,10,01..10,98; exactly 16 pops; occ=0.
REQ-039 Write 3 bytes 01,02,03 then idle -> after TIMEOUT cycles, frame A5,03,01,02,03,09 is emitted.
REQ-040 Drop tx_ready low for 5 cycles mid-DATA -> tx_data held stable, no fifo_read, frame content unchanged.
REQ-041 Write 20 bytes with tx_ready=1 -> first frame LEN=16; the remaining 4 bytes flush after timeout as a LEN=04 frame.
REQ-042 Write while fifo_full=1 -> overflow=1 and stays 1 until reset; occ does not exceed 32.
REQ-043 Assert reset during DATA -> next cycle tx_valid=0, busy=0, occ=0, and no CHK byte is emitted.
